// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 camera bring-up path: sequencer state
// encoding, default timing constants and the camera pin set per state.
package cam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PWDN  = 3'd1,
    ST_XCLK  = 3'd2,
    ST_RST   = 3'd3,
    ST_BOOT  = 3'd4,
    ST_CFG   = 3'd5,
    ST_READY = 3'd6,
    ST_FAIL  = 3'd7
  } cam_state_e;

  // Default timings in 100 MHz cycles.
  localparam int unsigned DEF_T_PWDN   = 100_000;
  localparam int unsigned DEF_T_XCLK   = 10_000;
  localparam int unsigned DEF_T_RST    = 1_000;
  localparam int unsigned DEF_T_BOOT   = 100_000;
  localparam int unsigned DEF_T_CFG_TO = 50_000_000;
  localparam int unsigned DEF_CNT_W    = 26;

  typedef struct packed {
    logic xclk_en;
    logic cam_pwdn;
    logic cam_reset_n;
  } cam_pins_t;

  // Camera pin levels held while the sequencer sits in a given state.
  function automatic cam_pins_t pins_for(cam_state_e s);
    cam_pins_t p;
    case (s)
      ST_IDLE, ST_PWDN: p = '{xclk_en: 1'b0, cam_pwdn: 1'b1, cam_reset_n: 1'b0};
      ST_XCLK, ST_RST:  p = '{xclk_en: 1'b1, cam_pwdn: 1'b0, cam_reset_n: 1'b0};
      default:          p = '{xclk_en: 1'b1, cam_pwdn: 1'b0, cam_reset_n: 1'b1};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/cam_clk_sequencer_if.sv
// Control, handshake and camera-pin bundle between the sequencer (master)
// and its surroundings: user control, SCCB config engine and the pin drivers.
interface cam_clk_sequencer_if;
  logic       start;
  logic       restart;
  logic       cfg_done;
  logic       cfg_err;
  logic       xclk_en;
  logic       cam_pwdn;
  logic       cam_reset_n;
  logic       cfg_start;
  logic       ready;
  logic       error;
  logic [2:0] state_o;

  modport master (
    input  start, restart, cfg_done, cfg_err,
    output xclk_en, cam_pwdn, cam_reset_n, cfg_start, ready, error, state_o
  );

  modport slave (
    output start, restart, cfg_done, cfg_err,
    input  xclk_en, cam_pwdn, cam_reset_n, cfg_start, ready, error, state_o
  );
endinterface

// File: rtl/delay_counter.sv
// Loadable down-counter: load takes priority, otherwise counts down and
// parks at zero. zero reflects the registered count.
module delay_counter #(
  parameter int unsigned W = 26
) (
  input  logic         clk100mhz,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk100mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cam_clk_sequencer.sv
// OV7670 power-up sequencer: PWDN hold, XCLK start, reset pulse, boot wait,
// then SCCB config handshake with timeout. Restartable at runtime.
module cam_clk_sequencer
  import cam_pkg::*;
#(
  parameter int unsigned T_PWDN   = DEF_T_PWDN,
  parameter int unsigned T_XCLK   = DEF_T_XCLK,
  parameter int unsigned T_RST    = DEF_T_RST,
  parameter int unsigned T_BOOT   = DEF_T_BOOT,
  parameter int unsigned T_CFG_TO = DEF_T_CFG_TO,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input logic                 clk100mhz,
  input logic                 rst_n,
  cam_clk_sequencer_if.master bus
);

  cam_state_e       state, nxt;
  logic             cnt_load, cnt_zero;
  logic [CNT_W-1:0] cnt_value;
  cam_pins_t        pins;
  logic             cfg_start_r, ready_r, error_r;

  delay_counter #(.W(CNT_W)) u_delay (
    .clk100mhz (clk100mhz),
    .rst_n     (rst_n),
    .load      (cnt_load),
    .value     (cnt_value),
    .zero      (cnt_zero)
  );

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned (no latch).
    nxt       = state;
    cnt_load  = 1'b0;
    cnt_value = '0;
    if (bus.restart) begin
      nxt       = ST_PWDN;
      cnt_load  = 1'b1;
      cnt_value = CNT_W'(T_PWDN - 1);
    end else if (state != ST_IDLE && !bus.start) begin
      nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) begin
          nxt       = ST_PWDN;
          cnt_load  = 1'b1;
          cnt_value = CNT_W'(T_PWDN - 1);
        end
        ST_PWDN: if (cnt_zero) begin
          nxt       = ST_XCLK;
          cnt_load  = 1'b1;
          cnt_value = CNT_W'(T_XCLK - 1);
        end
        ST_XCLK: if (cnt_zero) begin
          nxt       = ST_RST;
          cnt_load  = 1'b1;
          cnt_value = CNT_W'(T_RST - 1);
        end
        ST_RST: if (cnt_zero) begin
          nxt       = ST_BOOT;
          cnt_load  = 1'b1;
          cnt_value = CNT_W'(T_BOOT - 1);
        end
        ST_BOOT: if (cnt_zero) begin
          nxt       = ST_CFG;
          cnt_load  = 1'b1;
          cnt_value = CNT_W'(T_CFG_TO - 1);
        end
        // An error beats a simultaneous done; a done on the last timeout cycle still counts.
        ST_CFG: begin
          if (bus.cfg_err)       nxt = ST_FAIL;
          else if (bus.cfg_done) nxt = ST_READY;
          else if (cnt_zero)     nxt = ST_FAIL;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as state_o.
  always_ff @(posedge clk100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pins        <= pins_for(ST_IDLE);
      cfg_start_r <= 1'b0;
      ready_r     <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      // NOTE: non-blocking, so every register here samples the pre-edge state.
      state       <= nxt;
      pins        <= pins_for(nxt);
      cfg_start_r <= (nxt == ST_CFG) && (state != ST_CFG);
      ready_r     <= (nxt == ST_READY);
      if (nxt == ST_FAIL)      error_r <= 1'b1;
      else if (nxt == ST_PWDN) error_r <= 1'b0;
    end
  end

  assign bus.xclk_en     = pins.xclk_en;
  assign bus.cam_pwdn    = pins.cam_pwdn;
  assign bus.cam_reset_n = pins.cam_reset_n;
  assign bus.cfg_start   = cfg_start_r;
  assign bus.ready       = ready_r;
  assign bus.error       = error_r;
  assign bus.state_o     = state;

endmodule

// File: tb/tb_cam_clk_sequencer.sv
// Self-checking bench for cam_clk_sequencer: directed bring-up scenarios with
// literal timing expectations, then random stimulus against a timeline model.
module tb_cam_clk_sequencer;

  localparam int TP = 4, TX = 3, TR = 2, TB = 5, TO = 20;
  localparam int CFG_AT = TP + TX + TR + TB;  // elapsed cycles at which config starts
  localparam int M_IDLE = 0, M_RUN = 1, M_READY = 2, M_FAIL = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cam_clk_sequencer_if bus();

  cam_clk_sequencer #(
    .T_PWDN(TP), .T_XCLK(TX), .T_RST(TR), .T_BOOT(TB), .T_CFG_TO(TO), .CNT_W(8)
  ) dut (
    .clk100mhz (clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a bring-up is a run with elapsed-cycle count m_el since PWDN entry.
  int m_mode = M_IDLE;
  int m_el   = 0;
  bit m_err  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_el = 0; m_err = 1'b0;
    end else if (bus.restart) begin
      m_mode = M_RUN; m_el = 0; m_err = 1'b0;
    end else if (m_mode != M_IDLE && !bus.start) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (bus.start) begin m_mode = M_RUN; m_el = 0; m_err = 1'b0; end
    end else if (m_mode == M_RUN) begin
      if (m_el >= CFG_AT && bus.cfg_err)         begin m_mode = M_FAIL; m_err = 1'b1; end
      else if (m_el >= CFG_AT && bus.cfg_done)   m_mode = M_READY;
      else if (m_el == CFG_AT + TO - 1)          begin m_mode = M_FAIL; m_err = 1'b1; end
      else m_el++;
    end
  end

  function automatic int exp_state();
    if (m_mode == M_IDLE)  return 0;
    if (m_mode == M_READY) return 6;
    if (m_mode == M_FAIL)  return 7;
    if (m_el < TP)           return 1;
    if (m_el < TP + TX)      return 2;
    if (m_el < TP + TX + TR) return 3;
    if (m_el < CFG_AT)       return 4;
    return 5;
  endfunction

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("state_o",     bus.state_o,     exp_state());
      check("xclk_en",     bus.xclk_en,     exp_state() >= 2);
      check("cam_pwdn",    bus.cam_pwdn,    exp_state() <= 1);
      check("cam_reset_n", bus.cam_reset_n, exp_state() >= 4);
      check("cfg_start",   bus.cfg_start,   m_mode == M_RUN && m_el == CFG_AT);
      check("ready",       bus.ready,       m_mode == M_READY);
      check("error",       bus.error,       m_err);
      check("ready_and_error", bus.ready & bus.error, 0);
    end
  end

  task automatic pulse_restart();
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
  endtask

  task automatic wait_state(input int target, input int budget, input string what);
    int n = 0;
    while (bus.state_o !== 3'(target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({"reach_", what}, bus.state_o, target);
  endtask

  task automatic wait_cfg_start(input int budget);
    int n = 0;
    while (bus.cfg_start !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("reach_cfg_start", bus.cfg_start, 1);
  endtask

  int first_x, first_r, first_c, first_rdy, cs_k, n, pulses;
  int walk[$];
  int exp_walk[7] = '{0, 1, 2, 3, 4, 5, 6};

  initial begin
    bus.start = 1'b0; bus.restart = 1'b0; bus.cfg_done = 1'b0; bus.cfg_err = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_state",   bus.state_o, 0);
    check("rst_xclk",    bus.xclk_en, 0);
    check("rst_pwdn",    bus.cam_pwdn, 1);
    check("rst_reset_n", bus.cam_reset_n, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal bring-up: start raised in cycle 0, cfg_done 6 cycles after cfg_start.
    bus.start = 1'b1;
    first_x = -1; first_r = -1; first_c = -1; first_rdy = -1;
    walk.delete();
    walk.push_back(int'(bus.state_o));
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      bus.cfg_done = (k == 21);
      if (bus.xclk_en     && first_x   < 0) first_x   = k;
      if (bus.cam_reset_n && first_r   < 0) first_r   = k;
      if (bus.cfg_start   && first_c   < 0) first_c   = k;
      if (bus.ready       && first_rdy < 0) first_rdy = k;
      if (int'(bus.state_o) != walk[$]) walk.push_back(int'(bus.state_o));
    end
    check("nom_xclk_cycle",    first_x,   5);
    check("nom_reset_n_cycle", first_r,   10);
    check("nom_cfg_start_cyc", first_c,   15);
    check("nom_ready_cycle",   first_rdy, 22);
    check("walk_len", walk.size(), 7);
    for (int i = 0; i < 7 && i < walk.size(); i++) check("walk_step", walk[i], exp_walk[i]);

    // Restart from READY: immediate power-down, identical timing afterwards.
    pulse_restart();
    check("rs_state", bus.state_o, 1);
    check("rs_ready", bus.ready, 0);
    check("rs_xclk",  bus.xclk_en, 0);
    check("rs_pwdn",  bus.cam_pwdn, 1);
    cs_k = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.cfg_start) begin cs_k = k; break; end
    end
    check("rs_cfg_start_cyc", cs_k, CFG_AT);
    bus.cfg_done = 1'b1;
    @(negedge clk);
    bus.cfg_done = 1'b0;
    check("rs_ready_again", bus.ready, 1);

    // Config timeout: FAIL exactly TO cycles after cfg_start.
    pulse_restart();
    wait_cfg_start(40);
    n = 0;
    while (bus.state_o !== 3'd7 && n < 40) begin @(negedge clk); n++; end
    check("to_cycles", n, TO);
    check("to_error", bus.error, 1);
    check("to_ready", bus.ready, 0);
    check("to_xclk",  bus.xclk_en, 1);

    // Simultaneous done and err: error wins.
    pulse_restart();
    wait_cfg_start(40);
    bus.cfg_done = 1'b1; bus.cfg_err = 1'b1;
    @(negedge clk);
    bus.cfg_done = 1'b0; bus.cfg_err = 1'b0;
    check("both_state", bus.state_o, 7);
    check("both_error", bus.error, 1);
    check("both_ready", bus.ready, 0);

    // start falling in FAIL: back to IDLE with error held.
    bus.start = 1'b0;
    @(negedge clk);
    check("fall_state", bus.state_o, 0);
    check("fall_error", bus.error, 1);
    check("fall_xclk",  bus.xclk_en, 0);

    // start dropped mid-RST: IDLE next cycle, no config afterwards.
    bus.start = 1'b1;
    wait_state(3, 40, "rst");
    bus.start = 1'b0;
    @(negedge clk);
    check("drop_state",   bus.state_o, 0);
    check("drop_reset_n", bus.cam_reset_n, 0);
    check("drop_xclk",    bus.xclk_en, 0);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.cfg_start) pulses++;
    end
    check("drop_no_cfg", pulses, 0);

    // Asynchronous reset between edges in BOOT.
    bus.start = 1'b1;
    wait_state(4, 40, "boot");
    #2 rst_n = 1'b0;
    #1;
    check("ar_state",   bus.state_o, 0);
    check("ar_xclk",    bus.xclk_en, 0);
    check("ar_pwdn",    bus.cam_pwdn, 1);
    check("ar_reset_n", bus.cam_reset_n, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_restart_pwdn", bus.state_o, 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.restart  = ($urandom_range(0, 99) < 2);
      bus.cfg_done = ($urandom_range(0, 99) < 4);
      bus.cfg_err  = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 2) bus.start = ~bus.start;
    end
    bus.restart = 1'b0; bus.cfg_done = 1'b0; bus.cfg_err = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
